// File: rtl/regfile_scan_reader.sv
// Read-side register-file sweeper: walks FIRST_REG..LAST_REG through a
// combinational read port and streams (index, value) pairs over valid/ready.
module regfile_scan_reader #(
  parameter int unsigned FIRST_REG      = 0,
  parameter int unsigned LAST_REG       = 31,
  parameter int unsigned REFRESH_CYCLES = 0
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic        Abort,
  output logic [4:0]  RAdr,
  input  logic [31:0] RData,
  output logic [4:0]  OutIdx,
  output logic [31:0] OutData,
  output logic        OutValid,
  input  logic        OutReady,
  output logic        Busy,
  output logic        Done
);

  localparam int unsigned IDX_W   = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned CNT_MAX = (REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic               refresh_hit;
  logic               last_word;

  // The read port always follows the sweep index.
  assign RAdr = idx;

  // Auto-refresh fires only when the timer is enabled and has run its course.
  assign refresh_hit = (REFRESH_CYCLES != 0) && (cnt == CNT_W'(CNT_MAX));
  assign last_word   = (idx == IDX_W'(LAST_REG));

  // Sweep sequencer: IDLE waits for a trigger, LOAD captures one word, SEND hands it off.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= IDLE;
      idx      <= IDX_W'(FIRST_REG);
      cnt      <= '0;
      OutIdx   <= '0;
      OutData  <= '0;
      OutValid <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start || refresh_hit) begin
            idx   <= IDX_W'(FIRST_REG);
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= LOAD;
          end else if (cnt != CNT_W'(CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        LOAD: begin
          if (Abort) begin
            OutValid <= 1'b0;
            Busy     <= 1'b0;
            idx      <= IDX_W'(FIRST_REG);
            state    <= IDLE;
          end else begin
            // Register 0 reads as zero regardless of what the port returns.
            OutData  <= (idx == '0) ? DATA_W'(0) : RData;
            OutIdx   <= idx;
            OutValid <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (Abort) begin
            OutValid <= 1'b0;
            Busy     <= 1'b0;
            idx      <= IDX_W'(FIRST_REG);
            state    <= IDLE;
          end else if (OutReady) begin
            OutValid <= 1'b0;
            if (last_word) begin
              Busy  <= 1'b0;
              Done  <= 1'b1;
              state <= IDLE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= LOAD;
            end
          end
        end
        default: begin
          OutValid <= 1'b0;
          Busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Bench for regfile_scan_reader: a full-range instance and a refreshing
// 4..6 instance share one register file and are checked every cycle.
module tb_regfile_scan_reader;

  localparam int unsigned F0 = 0;
  localparam int unsigned L0 = 31;
  localparam int unsigned R0 = 0;
  localparam int unsigned F1 = 4;
  localparam int unsigned L1 = 6;
  localparam int unsigned R1 = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st[2];
  logic        ab[2];
  logic        rdy[2];
  logic [4:0]  radr[2];
  logic [4:0]  oidx[2];
  logic [31:0] rdata[2];
  logic [31:0] odata[2];
  logic        oval[2];
  logic        busy[2];
  logic        done[2];
  logic [31:0] regs[32];

  assign rdata[0] = regs[radr[0]];
  assign rdata[1] = regs[radr[1]];

  regfile_scan_reader #(.FIRST_REG(F0), .LAST_REG(L0), .REFRESH_CYCLES(R0)) dut_a (
    .Clk(clk), .Rst_n(rst_n), .Start(st[0]), .Abort(ab[0]), .RAdr(radr[0]),
    .RData(rdata[0]), .OutIdx(oidx[0]), .OutData(odata[0]), .OutValid(oval[0]),
    .OutReady(rdy[0]), .Busy(busy[0]), .Done(done[0]));

  regfile_scan_reader #(.FIRST_REG(F1), .LAST_REG(L1), .REFRESH_CYCLES(R1)) dut_b (
    .Clk(clk), .Rst_n(rst_n), .Start(st[1]), .Abort(ab[1]), .RAdr(radr[1]),
    .RData(rdata[1]), .OutIdx(oidx[1]), .OutData(odata[1]), .OutValid(oval[1]),
    .OutReady(rdy[1]), .Busy(busy[1]), .Done(done[1]));

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  // Reference model: which words remain, when the next one becomes visible.
  bit          m_busy[2];
  bit          m_valid[2];
  bit          m_done[2];
  int          m_cd[2];
  int          m_next[2];
  int          m_idle[2];
  int          m_idx[2];
  int          m_radr[2];
  logic [31:0] m_data[2];

  // Observation bookkeeping.
  bit          pv[2];
  logic [4:0]  pidx[2];
  logic [31:0] pdata[2];
  bit          prev_busy[2];
  int          t_load[2];
  int          t_done[2];
  int          n_done[2];
  int          hs_cnt[2];
  int          acc_idx[$];
  logic [31:0] acc_data[$];
  bit          gap_chk;

  bit          wr_en;
  int          wr_addr;
  logic [31:0] wr_data;

  typedef struct {
    bit          rst_n;
    bit          start;
    bit          abort;
    bit          ready;
    bit          v;
    bit          b;
    bit          dn;
    logic [4:0]  radr;
    logic [4:0]  idx;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[18];

  function automatic int first_of(input int d);
    return (d == 0) ? int'(F0) : int'(F1);
  endfunction

  function automatic int last_of(input int d);
    return (d == 0) ? int'(L0) : int'(L1);
  endfunction

  function automatic int refresh_of(input int d);
    return (d == 0) ? int'(R0) : int'(R1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs that were applied.
  task automatic model_update(input int d);
    if (!rst_n) begin
      m_busy[d] = 1'b0; m_valid[d] = 1'b0; m_done[d] = 1'b0;
      m_cd[d] = 0; m_idle[d] = 0;
      m_next[d] = first_of(d); m_radr[d] = first_of(d);
      return;
    end
    m_done[d] = 1'b0;
    if (!m_busy[d]) begin
      m_idle[d]++;
      if (st[d] || (refresh_of(d) != 0 && m_idle[d] >= refresh_of(d))) begin
        m_busy[d] = 1'b1; m_next[d] = first_of(d); m_radr[d] = first_of(d);
        m_cd[d] = 2; m_idle[d] = 0;
      end
    end else if (ab[d]) begin
      m_busy[d] = 1'b0; m_valid[d] = 1'b0; m_cd[d] = 0; m_radr[d] = first_of(d);
    end else if (m_valid[d] && rdy[d]) begin
      m_valid[d] = 1'b0;
      if (m_next[d] > last_of(d)) begin
        m_busy[d] = 1'b0; m_done[d] = 1'b1;
      end else begin
        m_cd[d] = 2; m_radr[d] = m_next[d];
      end
    end
    if (m_cd[d] > 0) begin
      m_cd[d]--;
      if (m_cd[d] == 0) begin
        m_idx[d]  = m_next[d];
        m_next[d] = m_next[d] + 1;
        m_data[d] = (m_idx[d] == 0) ? 32'd0 : regs[m_idx[d]];
        m_valid[d] = 1'b1;
      end
    end
  endtask

  task automatic compare(input int d);
    chk($sformatf("valid[%0d]", d), 32'(oval[d]), 32'(m_valid[d]));
    chk($sformatf("busy[%0d]", d), 32'(busy[d]), 32'(m_busy[d]));
    chk($sformatf("done[%0d]", d), 32'(done[d]), 32'(m_done[d]));
    chk($sformatf("radr[%0d]", d), 32'(radr[d]), 32'(m_radr[d]));
    chk($sformatf("done_with_valid[%0d]", d), 32'(done[d] & oval[d]), 32'd0);
    if (!rst_n) begin
      chk($sformatf("rst_idx[%0d]", d), 32'(oidx[d]), 32'd0);
      chk($sformatf("rst_data[%0d]", d), odata[d], 32'd0);
    end else if (m_valid[d]) begin
      chk($sformatf("idx[%0d]", d), 32'(oidx[d]), 32'(m_idx[d]));
      chk($sformatf("data[%0d]", d), odata[d], m_data[d]);
    end
  endtask

  // One clock: optional register write on the falling edge, sample 1ns after the rising edge.
  task automatic step();
    @(negedge clk);
    if (wr_en) begin
      regs[wr_addr] = wr_data;
      wr_en = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst_n && pv[d] && rdy[d]) begin
        hs_cnt[d]++;
        if (d == 0) begin
          acc_idx.push_back(int'(pidx[d]));
          acc_data.push_back(pdata[d]);
        end
      end
      model_update(d);
      compare(d);
      if (!rst_n) t_done[d] = 0;
      if (busy[d] === 1'b1 && !prev_busy[d]) begin
        if (d == 1 && gap_chk && t_done[d] > 0) chk("refresh_gap", 32'(cyc - t_done[d]), 32'd10);
        t_load[d] = cyc;
      end
      if (done[d] === 1'b1) begin
        n_done[d]++;
        if (d == 1 && gap_chk) chk("b_sweep_len", 32'(cyc - t_load[d]), 32'd6);
        t_done[d] = cyc;
      end
      pv[d] = (oval[d] === 1'b1); pidx[d] = oidx[d]; pdata[d] = odata[d];
      prev_busy[d] = (busy[d] === 1'b1);
    end
  endtask

  task automatic wait_done(input int d, input int budget);
    int i = 0;
    while (done[d] !== 1'b1 && i < budget) begin
      step();
      i++;
    end
    chk($sformatf("wait_done_timeout[%0d]", d), 32'(done[d] === 1'b1), 32'd1);
  endtask

  initial begin
    int nd;
    int stall_n;
    int i;
    bit wrote;
    logic [31:0] expv;

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 0; wr_data = '0; gap_chk = 1'b0;
    for (int d = 0; d < 2; d++) begin
      st[d] = 1'b0; ab[d] = 1'b0; rdy[d] = 1'b1;
      pv[d] = 1'b0; pidx[d] = '0; pdata[d] = '0; prev_busy[d] = 1'b0;
      t_load[d] = 0; t_done[d] = 0; n_done[d] = 0; hs_cnt[d] = 0;
      m_busy[d] = 1'b0; m_valid[d] = 1'b0; m_done[d] = 1'b0; m_cd[d] = 0;
      m_next[d] = first_of(d); m_idle[d] = 0; m_idx[d] = 0; m_radr[d] = first_of(d); m_data[d] = '0;
    end
    for (int k = 0; k < 32; k++) regs[k] = 32'h1000_0000 + 32'(k);

    //             rst  st  ab  rdy  v   b   dn  radr   idx    data
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 5'd1, 32'h1000_0001};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 32'h0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 32'h0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 32'h0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 5'd1, 32'h1000_0001};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0};

    for (int t = 0; t < 18; t++) begin
      rst_n = tbl[t].rst_n; st[0] = tbl[t].start; ab[0] = tbl[t].abort; rdy[0] = tbl[t].ready;
      step();
      chk($sformatf("tbl%0d_valid", t), 32'(oval[0]), 32'(tbl[t].v));
      chk($sformatf("tbl%0d_busy", t), 32'(busy[0]), 32'(tbl[t].b));
      chk($sformatf("tbl%0d_done", t), 32'(done[0]), 32'(tbl[t].dn));
      chk($sformatf("tbl%0d_radr", t), 32'(radr[0]), 32'(tbl[t].radr));
      if (tbl[t].v) begin
        chk($sformatf("tbl%0d_idx", t), 32'(oidx[0]), 32'(tbl[t].idx));
        chk($sformatf("tbl%0d_data", t), odata[0], tbl[t].data);
      end
    end
    st[0] = 1'b0; ab[0] = 1'b0; rdy[0] = 1'b1;

    // Reset, then a long idle stretch: A stays quiet, B refreshes on its own.
    gap_chk = 1'b1;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    nd = n_done[0];
    i = n_done[1];
    repeat (100) step();
    chk("idle_no_done", 32'(n_done[0] - nd), 32'd0);
    chk("idle_b_refreshed", 32'(n_done[1] - i >= 5), 32'd1);

    // Full sweep with ready held high.
    acc_idx.delete(); acc_data.delete();
    st[0] = 1'b1; step(); st[0] = 1'b0;
    wait_done(0, 200);
    chk("full_len", 32'(t_done[0] - t_load[0]), 32'd64);
    chk("full_words", 32'(acc_idx.size()), 32'd32);
    for (int k = 0; k < 32 && k < acc_idx.size(); k++) begin
      expv = (k == 0) ? 32'h0 : 32'h1000_0000 + 32'(k);
      chk($sformatf("full_idx%0d", k), 32'(acc_idx[k]), 32'(k));
      chk($sformatf("full_data%0d", k), acc_data[k], expv);
    end

    // Backpressure on word 7, concurrent write to reg 12 during its LOAD.
    acc_idx.delete(); acc_data.delete();
    stall_n = 0; wrote = 1'b0; i = 0;
    st[0] = 1'b1; step(); st[0] = 1'b0;
    while (done[0] !== 1'b1 && i < 300) begin
      if (oval[0] === 1'b1 && oidx[0] == 5'd7 && stall_n < 5) begin
        if (stall_n > 0) begin
          chk("hold_idx", 32'(oidx[0]), 32'd7);
          chk("hold_data", odata[0], 32'h1000_0007);
        end
        rdy[0] = 1'b0; stall_n++;
      end else begin
        rdy[0] = 1'b1;
      end
      if (!wrote && oval[0] === 1'b0 && busy[0] === 1'b1 && radr[0] == 5'd12) begin
        wr_en = 1'b1; wr_addr = 12; wr_data = 32'hDEAD_BEEF; wrote = 1'b1;
      end
      step();
      i++;
    end
    rdy[0] = 1'b1;
    chk("bp_done", 32'(done[0] === 1'b1), 32'd1);
    chk("bp_len", 32'(t_done[0] - t_load[0]), 32'd69);
    chk("bp_words", 32'(acc_idx.size()), 32'd32);
    for (int k = 0; k < 32 && k < acc_idx.size(); k++) begin
      expv = (k == 0) ? 32'h0 : (k == 12) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(k);
      chk($sformatf("bp_idx%0d", k), 32'(acc_idx[k]), 32'(k));
      chk($sformatf("bp_data%0d", k), acc_data[k], expv);
    end
    regs[12] = 32'h1000_000C;

    // Abort while presenting word 5, then restart from the first register.
    st[0] = 1'b1; step(); st[0] = 1'b0;
    i = 0;
    while (!(oval[0] === 1'b1 && oidx[0] == 5'd5) && i < 50) begin step(); i++; end
    chk("abort_reach5", 32'(oval[0] === 1'b1 && oidx[0] == 5'd5), 32'd1);
    nd = n_done[0];
    ab[0] = 1'b1; rdy[0] = 1'b0; step(); ab[0] = 1'b0; rdy[0] = 1'b1;
    chk("abort_valid", 32'(oval[0]), 32'd0);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    repeat (3) step();
    chk("abort_no_done", 32'(n_done[0] - nd), 32'd0);
    st[0] = 1'b1; step(); st[0] = 1'b0;
    i = 0;
    while (oval[0] !== 1'b1 && i < 10) begin step(); i++; end
    chk("restart_idx", 32'(oidx[0]), 32'd0);
    wait_done(0, 200);

    // B: Start on the same cycle as refresh expiry, then a Start during a sweep.
    wait_done(1, 60);
    repeat (9) step();
    hs_cnt[1] = 0;
    st[1] = 1'b1; step(); st[1] = 1'b0;
    chk("coincide_busy", 32'(busy[1]), 32'd1);
    chk("coincide_gap", 32'(t_load[1] - t_done[1]), 32'd10);
    wait_done(1, 20);
    chk("coincide_words", 32'(hs_cnt[1]), 32'd3);
    i = 0;
    while (!(busy[1] === 1'b1 && oval[1] === 1'b0) && i < 30) begin step(); i++; end
    hs_cnt[1] = 0;
    step();
    st[1] = 1'b1; step(); st[1] = 1'b0;
    wait_done(1, 20);
    chk("midstart_words", 32'(hs_cnt[1]), 32'd3);
    i = 0;
    while (busy[1] !== 1'b1 && i < 30) begin step(); i++; end
    chk("midstart_not_queued", 32'(t_load[1] - t_done[1]), 32'd10);

    // Random traffic on both instances against the model.
    gap_chk = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int d = 0; d < 2; d++) begin
        st[d]  = ($urandom_range(9) == 0);
        ab[d]  = ($urandom_range(49) == 0);
        rdy[d] = ($urandom_range(1) == 1);
      end
      if ($urandom_range(3) == 0) begin
        wr_en = 1'b1; wr_addr = int'($urandom_range(31)); wr_data = $urandom;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
